// File: rtl/vend_dispense_ctrl.sv
// Dispense stage behind the payment FSM: release FIFO, slot-motor and coin-hopper handshakes, stock and sales tracking.
// Optional macro SALES_TOTAL_EN builds the sales accumulator; without it sales_total is tied to 0.
module vend_dispense_ctrl #(
    parameter int STOCK_INIT    = 8,
    parameter int STOCK_W       = 4,
    parameter int FIFO_DEPTH    = 4,
    parameter int MOTOR_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         item_rels,
    input  logic               change_return,
    input  logic               motor_done,
    input  logic               coin_ack,
    input  logic               restock,
    input  logic [1:0]         restock_item,
    input  logic [STOCK_W-1:0] restock_qty,
    output logic [3:0]         motor_en,
    output logic               coin_eject,
    output logic [3:0]         sold_out,
    output logic               busy,
    output logic               jam,
    output logic               drop_err,
    output logic [11:0]        sales_total
);
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int WAIT_W = (MOTOR_TIMEOUT > 1) ? $clog2(MOTOR_TIMEOUT + 1) : 1;
    localparam logic [STOCK_W-1:0] STOCK_MAX = '1;
    localparam logic [STOCK_W-1:0] STOCK_RST = STOCK_W'(STOCK_INIT);

    typedef enum logic [1:0] {M_IDLE, M_RUN, M_JAM} motor_state_t;
    typedef enum logic [1:0] {C_IDLE, C_EJECT, C_GAP} coin_state_t;

    motor_state_t       m_state, m_next;
    coin_state_t        c_state, c_next;

    logic               rels_prev;
    logic               rel_event;

    logic [1:0]         fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   fifo_cnt;
    logic               fifo_full, fifo_empty;
    logic               push, pop;
    logic [1:0]         head_item;

    logic [1:0]         cur_item;
    logic [WAIT_W-1:0]  wait_cnt;
    logic               head_stock_zero;
    logic               vend_done;
    logic               timeout;

    logic [STOCK_W-1:0] stock      [4];
    logic [STOCK_W-1:0] stock_next [4];
    logic [STOCK_W:0]   stock_sum  [4];

    logic [4:0]         coin_pend;
    logic               coin_dec;

    // A code held across several cycles is a single release.
    assign rel_event = item_rels[2] & ~rels_prev;

    always_ff @(posedge clk) begin
        if (reset) rels_prev <= 1'b0;
        else       rels_prev <= item_rels[2];
    end

    assign fifo_full  = (fifo_cnt == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (fifo_cnt == '0);
    assign push       = rel_event & ~fifo_full;
    assign pop        = (m_state == M_IDLE) & ~fifo_empty;
    assign head_item  = fifo_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= item_rels[1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    assign head_stock_zero = (stock[head_item] == '0);
    assign vend_done       = (m_state == M_RUN) & motor_done;
    assign timeout         = (m_state == M_RUN) & ~motor_done & (wait_cnt == WAIT_W'(MOTOR_TIMEOUT));

    always_ff @(posedge clk) begin
        if (reset) m_state <= M_IDLE;
        else       m_state <= m_next;
    end

    always_comb begin
        m_next = m_state;
        case (m_state)
            M_IDLE:  if (pop && !head_stock_zero) m_next = M_RUN;
            M_RUN: begin
                if (motor_done)   m_next = M_IDLE;
                else if (timeout) m_next = M_JAM;
            end
            M_JAM:   m_next = M_JAM;
            default: m_next = M_IDLE;
        endcase
    end

    always_comb begin
        motor_en = '0;
        jam      = 1'b0;
        case (m_state)
            M_RUN:   motor_en[cur_item] = 1'b1;
            M_JAM:   jam = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_item <= '0;
            wait_cnt <= '0;
            drop_err <= 1'b0;
        end else begin
            if (pop) cur_item <= head_item;
            if (m_state == M_RUN) wait_cnt <= wait_cnt + 1'b1;
            else                  wait_cnt <= '0;
            drop_err <= (rel_event & fifo_full) | (pop & head_stock_zero);
        end
    end

    // Restock and a completing vend on the same slot combine before saturating.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            stock_sum[i] = {1'b0, stock[i]};
            if (restock && restock_item == 2'(i))
                stock_sum[i] = stock_sum[i] + {1'b0, restock_qty};
            if (vend_done && cur_item == 2'(i))
                stock_sum[i] = stock_sum[i] - 1'b1;
            if (stock_sum[i] > {1'b0, STOCK_MAX})
                stock_next[i] = STOCK_MAX;
            else
                stock_next[i] = stock_sum[i][STOCK_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) stock[i] <= STOCK_RST;
            sold_out <= (STOCK_INIT == 0) ? 4'hF : 4'h0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                stock[i]    <= stock_next[i];
                sold_out[i] <= (stock[i] == '0);
            end
        end
    end

`ifdef SALES_TOTAL_EN
    logic [12:0] sales_sum;
    assign sales_sum = {1'b0, sales_total} + {11'd0, cur_item} + 13'd2;

    always_ff @(posedge clk) begin
        if (reset)          sales_total <= '0;
        else if (vend_done) sales_total <= (sales_sum > 13'd4095) ? 12'hFFF : sales_sum[11:0];
    end
`else
    assign sales_total = '0;
`endif

    assign coin_dec = coin_eject & coin_ack;

    always_ff @(posedge clk) begin
        if (reset) begin
            coin_pend <= '0;
        end else begin
            case ({change_return, coin_dec})
                2'b10:   if (coin_pend != 5'd31) coin_pend <= coin_pend + 1'b1;
                2'b01:   coin_pend <= coin_pend - 1'b1;
                default: coin_pend <= coin_pend;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) c_state <= C_IDLE;
        else       c_state <= c_next;
    end

    // The gap cycle re-arms the hopper directly so consecutive coins are separated by exactly one low cycle.
    always_comb begin
        c_next = c_state;
        case (c_state)
            C_IDLE:  if (coin_pend != '0) c_next = C_EJECT;
            C_EJECT: if (coin_ack) c_next = C_GAP;
            C_GAP:   c_next = (coin_pend != '0) ? C_EJECT : C_IDLE;
            default: c_next = C_IDLE;
        endcase
    end

    always_comb begin
        coin_eject = (c_state == C_EJECT);
    end

    assign busy = ~fifo_empty | (m_state == M_RUN) | (coin_pend != '0);

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Directed bench for vend_dispense_ctrl: a cycle table for the basic vend and coin train,
// then hand-written sequences for FIFO overflow, sold-out/restock, motor jam and reset mid-vend.
module tb_vend_dispense_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  item_rels;
    logic        change_return;
    logic        motor_done;
    logic        coin_ack;
    logic        restock;
    logic [1:0]  restock_item;
    logic [3:0]  restock_qty;
    logic [3:0]  motor_en;
    logic        coin_eject;
    logic [3:0]  sold_out;
    logic        busy;
    logic        jam;
    logic        drop_err;
    logic [11:0] sales_total;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0] rels;
        logic       cr;
        logic       done;
        logic       ack;
        logic [3:0] exp_motor;
        logic       exp_eject;
        logic       exp_busy;
    } vec_t;

    vec_t vecs[$];

    vend_dispense_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .item_rels     (item_rels),
        .change_return (change_return),
        .motor_done    (motor_done),
        .coin_ack      (coin_ack),
        .restock       (restock),
        .restock_item  (restock_item),
        .restock_qty   (restock_qty),
        .motor_en      (motor_en),
        .coin_eject    (coin_eject),
        .sold_out      (sold_out),
        .busy          (busy),
        .jam           (jam),
        .drop_err      (drop_err),
        .sales_total   (sales_total)
    );

    always #5 clk = ~clk;

    function automatic int exp_sales(input int v);
`ifdef SALES_TOTAL_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [2:0] rels, input logic cr, input logic done, input logic ack);
        item_rels     = rels;
        change_return = cr;
        motor_done    = done;
        coin_ack      = ack;
        tick();
    endtask

    task automatic add_vec(input logic [2:0] rels, input logic cr, input logic done, input logic ack,
                           input logic [3:0] m, input logic e, input logic b);
        vec_t v;
        v.rels = rels; v.cr = cr; v.done = done; v.ack = ack;
        v.exp_motor = m; v.exp_eject = e; v.exp_busy = b;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        item_rels = 3'b000; change_return = 1'b0; motor_done = 1'b0; coin_ack = 1'b0;
        restock = 1'b0; restock_item = 2'd0; restock_qty = 4'd0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Waits for a motor to be driven; an expired bound is a failed comparison.
    task automatic wait_motor(input string name, output logic [3:0] got);
        int n = 0;
        while (motor_en == 4'b0 && n < 20) begin
            tick();
            n++;
        end
        got = motor_en;
        if (motor_en == 4'b0) begin
            total++;
            bad++;
            $display("[TB] FAIL %s: motor_en never rose within 20 cycles", name);
        end
    endtask

    task automatic vend(input string name, input logic [1:0] item, input logic do_restock);
        logic [3:0] got;
        item_rels = {1'b1, item};
        tick();
        item_rels = 3'b000;
        wait_motor(name, got);
        check_output({name, " motor_en"}, got, 4'b0001 << item);
        motor_done = 1'b1;
        if (do_restock) begin
            restock = 1'b1; restock_item = item; restock_qty = 4'd1;
        end
        tick();
        motor_done = 1'b0;
        restock = 1'b0;
        check_output({name, " motor_en off"}, motor_en, 4'b0000);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [3:0] got;
        int         cnt;
        logic       seen;
        logic [1:0] ovf_items [6];
        logic [1:0] vend_items [5];

        // Basic tea vend, then three owed coins acknowledged two cycles after each eject rise.
        add_vec(3'b101, 0, 0, 0, 4'b0000, 0, 1);
        for (int i = 0; i < 5; i++) add_vec(3'b000, 0, 0, 0, 4'b0010, 0, 1);
        add_vec(3'b000, 0, 1, 0, 4'b0000, 0, 0);
        add_vec(3'b000, 0, 0, 0, 4'b0000, 0, 0);
        add_vec(3'b000, 1, 0, 0, 4'b0000, 0, 1);
        add_vec(3'b000, 1, 0, 0, 4'b0000, 1, 1);
        add_vec(3'b000, 1, 0, 0, 4'b0000, 1, 1);
        for (int c = 0; c < 3; c++) begin
            if (c > 0) begin
                add_vec(3'b000, 0, 0, 0, 4'b0000, 1, 1);
                add_vec(3'b000, 0, 0, 0, 4'b0000, 1, 1);
            end
            add_vec(3'b000, 0, 0, 0, 4'b0000, 1, 1);
            add_vec(3'b000, 0, 0, 1, 4'b0000, 0, (c < 2) ? 1'b1 : 1'b0);
        end
        add_vec(3'b000, 0, 0, 0, 4'b0000, 0, 0);
        add_vec(3'b000, 0, 0, 0, 4'b0000, 0, 0);

        ovf_items  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        vend_items = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        do_reset();
        check_output("reset motor_en",    motor_en,    4'b0000);
        check_output("reset coin_eject",  coin_eject,  1'b0);
        check_output("reset sold_out",    sold_out,    4'b0000);
        check_output("reset busy",        busy,        1'b0);
        check_output("reset jam",         jam,         1'b0);
        check_output("reset drop_err",    drop_err,    1'b0);
        check_output("reset sales_total", sales_total, 12'd0);

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].rels, vecs[i].cr, vecs[i].done, vecs[i].ack);
            check_output($sformatf("vec%0d motor_en", i),   motor_en,   vecs[i].exp_motor);
            check_output($sformatf("vec%0d coin_eject", i), coin_eject, vecs[i].exp_eject);
            check_output($sformatf("vec%0d busy", i),       busy,       vecs[i].exp_busy);
            check_output($sformatf("vec%0d drop_err", i),   drop_err,   1'b0);
        end
        check_output("table sales_total", sales_total, exp_sales(3));

        // Six releases against a stalled motor: one in service, four buffered, the sixth dropped.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            apply_stimulus({1'b1, ovf_items[k]}, 0, 0, 0);
            check_output($sformatf("ovf drop r%0d", k), drop_err, (k == 5) ? 1'b1 : 1'b0);
            apply_stimulus(3'b000, 0, 0, 0);
            check_output($sformatf("ovf drop gap%0d", k), drop_err, 1'b0);
        end
        check_output("ovf in service", motor_en, 4'b0001);
        for (int j = 0; j < 5; j++) begin
            wait_motor($sformatf("ovf vend%0d", j), got);
            check_output($sformatf("ovf vend%0d motor_en", j), got, 4'b0001 << vend_items[j]);
            apply_stimulus(3'b000, 0, 1, 0);
            check_output($sformatf("ovf vend%0d off", j), motor_en, 4'b0000);
        end
        for (int n = 0; n < 3; n++) apply_stimulus(3'b000, 0, 0, 0);
        check_output("ovf idle motor_en", motor_en, 4'b0000);
        check_output("ovf idle busy", busy, 1'b0);
        check_output("ovf sales_total", sales_total, exp_sales(16));

        // Empty the juice slot, attempt a release, then restock and vend again.
        do_reset();
        for (int n = 0; n < 8; n++) vend($sformatf("juice%0d", n), 2'd3, 1'b0);
        check_output("sold_out lag", sold_out, 4'b0000);
        tick();
        check_output("sold_out juice", sold_out, 4'b1000);
        apply_stimulus(3'b111, 0, 0, 0);
        check_output("empty push drop_err", drop_err, 1'b0);
        apply_stimulus(3'b000, 0, 0, 0);
        check_output("empty pop drop_err", drop_err, 1'b1);
        check_output("empty pop motor_en", motor_en, 4'b0000);
        apply_stimulus(3'b000, 0, 0, 0);
        check_output("empty drop_err end", drop_err, 1'b0);
        check_output("empty motor_en", motor_en, 4'b0000);
        check_output("empty busy", busy, 1'b0);
        restock = 1'b1; restock_item = 2'd3; restock_qty = 4'd2;
        tick();
        restock = 1'b0;
        check_output("restock lag", sold_out, 4'b1000);
        tick();
        check_output("restock sold_out", sold_out, 4'b0000);
        vend("juice after restock", 2'd3, 1'b0);
        vend("juice with restock", 2'd3, 1'b1);
        tick();
        tick();
        check_output("restock+vend sold_out", sold_out, 4'b0000);
        vend("juice last", 2'd3, 1'b0);
        tick();
        tick();
        check_output("juice last sold_out", sold_out, 4'b1000);
        check_output("juice sales_total", sales_total, exp_sales(55));

        // Motor never finishes: jam after the timeout, coin path keeps working.
        do_reset();
        apply_stimulus(3'b110, 0, 0, 0);
        item_rels = 3'b000;
        cnt = 0;
        seen = 1'b0;
        for (int n = 0; n < 400; n++) begin
            tick();
            if (jam) begin
                seen = 1'b1;
                break;
            end
            if (motor_en != 4'b0) cnt++;
        end
        check_output("jam seen", seen, 1'b1);
        check_output("jam run cycles", cnt, 256);
        check_output("jam motor_en", motor_en, 4'b0000);
        check_output("jam sold_out", sold_out, 4'b0000);
        apply_stimulus(3'b000, 1, 0, 0);
        change_return = 1'b0;
        cnt = 0;
        while (!coin_eject && cnt < 20) begin
            tick();
            cnt++;
        end
        check_output("jam coin_eject", coin_eject, 1'b1);
        apply_stimulus(3'b000, 0, 0, 1);
        coin_ack = 1'b0;
        check_output("jam coin done", coin_eject, 1'b0);
        tick();
        tick();
        check_output("jam busy idle", busy, 1'b0);
        check_output("jam sticky", jam, 1'b1);
        apply_stimulus(3'b101, 0, 0, 0);
        apply_stimulus(3'b000, 0, 0, 0);
        check_output("jam fifo busy", busy, 1'b1);
        check_output("jam no motor", motor_en, 4'b0000);
        check_output("jam sales_total", sales_total, 12'd0);
        do_reset();
        check_output("jam cleared", jam, 1'b0);
        check_output("jam reset busy", busy, 1'b0);

        // Reset while the motor runs and a coin is being ejected.
        apply_stimulus(3'b101, 1, 0, 0);
        apply_stimulus(3'b000, 1, 0, 0);
        change_return = 1'b0;
        check_output("mid motor_en", motor_en, 4'b0010);
        check_output("mid coin_eject", coin_eject, 1'b1);
        reset = 1'b1;
        tick();
        check_output("rst motor_en", motor_en, 4'b0000);
        check_output("rst coin_eject", coin_eject, 1'b0);
        check_output("rst busy", busy, 1'b0);
        reset = 1'b0;
        for (int n = 0; n < 3; n++) tick();
        check_output("post rst coin_eject", coin_eject, 1'b0);
        check_output("post rst motor_en", motor_en, 4'b0000);
        check_output("post rst busy", busy, 1'b0);
        check_output("post rst sales_total", sales_total, 12'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
